// File: rtl/intersection_pkg.sv
// Shared phase codes, direction indices and default dwell times for the intersection controller.
// Optional SENSOR_SKIP_EN in phase_sequencer uses the pair masks below to skip idle left phases.
package intersection_pkg;

    typedef enum logic [2:0] {
        NS_LEFT   = 3'd0,
        NS_GREEN  = 3'd1,
        NS_YELLOW = 3'd2,
        NS_ALLRED = 3'd3,
        EW_LEFT   = 3'd4,
        EW_GREEN  = 3'd5,
        EW_YELLOW = 3'd6,
        EW_ALLRED = 3'd7
    } phase_e;

    localparam int N = 0;
    localparam int S = 1;
    localparam int E = 2;
    localparam int W = 3;

    localparam int DEF_T_LEFT   = 4;
    localparam int DEF_T_GREEN  = 10;
    localparam int DEF_T_YELLOW = 3;
    localparam int DEF_T_ALLRED = 1;
    localparam int DEF_CNT_W    = 8;

    localparam logic [3:0] NS_PAIR = 4'((1 << N) | (1 << S));
    localparam logic [3:0] EW_PAIR = 4'((1 << E) | (1 << W));

    function automatic phase_e nominalNext(input phase_e p);
        case (p)
            NS_LEFT:   return NS_GREEN;
            NS_GREEN:  return NS_YELLOW;
            NS_YELLOW: return NS_ALLRED;
            NS_ALLRED: return EW_LEFT;
            EW_LEFT:   return EW_GREEN;
            EW_GREEN:  return EW_YELLOW;
            EW_YELLOW: return EW_ALLRED;
            default:   return NS_LEFT;
        endcase
    endfunction

    // The upper code bit selects the east-west axis.
    function automatic logic [3:0] pairMask(input phase_e p);
        return p[2] ? EW_PAIR : NS_PAIR;
    endfunction

endpackage

// File: rtl/phase_timer.sv
// Loadable dwell down-counter: load wins over tick, counting stops at zero and done flags zero.
module phase_timer #(
    parameter int               CNT_W   = 8,
    parameter logic [CNT_W-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             load,
    input  logic [CNT_W-1:0] loadVal,
    input  logic             tick,
    output logic             done
);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            count <= RST_VAL;
        end else if (load) begin
            count <= loadVal;
        end else if (tick && (count != '0)) begin
            count <= count - CNT_W'(1);
        end
    end

    assign done = (count == '0);

endmodule

// File: rtl/phase_sequencer.sv
// Eight-phase intersection sequencer with sticky left-turn request latches and Moore lamp decode.
// Define SENSOR_SKIP_EN to jump from all-red straight to the next green when that pair has no left request.
module phase_sequencer
    import intersection_pkg::*;
#(
    parameter int T_LEFT   = DEF_T_LEFT,
    parameter int T_GREEN  = DEF_T_GREEN,
    parameter int T_YELLOW = DEF_T_YELLOW,
    parameter int T_ALLRED = DEF_T_ALLRED,
    parameter int CNT_W    = DEF_CNT_W
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       tick,
    input  logic [3:0] leftReq,
    output logic [3:0] phase,
    output logic [3:0] greenOut,
    output logic [3:0] yellowOut,
    output logic [3:0] redOut,
    output logic [3:0] leftOut
);

    // A zero dwell is stretched to one tick so every phase is visible for at least one tick.
    localparam logic [CNT_W-1:0] LD_LEFT   = CNT_W'(((T_LEFT   < 1) ? 1 : T_LEFT)   - 1);
    localparam logic [CNT_W-1:0] LD_GREEN  = CNT_W'(((T_GREEN  < 1) ? 1 : T_GREEN)  - 1);
    localparam logic [CNT_W-1:0] LD_YELLOW = CNT_W'(((T_YELLOW < 1) ? 1 : T_YELLOW) - 1);
    localparam logic [CNT_W-1:0] LD_ALLRED = CNT_W'(((T_ALLRED < 1) ? 1 : T_ALLRED) - 1);

    function automatic logic [CNT_W-1:0] loadFor(input phase_e p);
        case (p)
            NS_LEFT,   EW_LEFT:   return LD_LEFT;
            NS_GREEN,  EW_GREEN:  return LD_GREEN;
            NS_YELLOW, EW_YELLOW: return LD_YELLOW;
            default:              return LD_ALLRED;
        endcase
    endfunction

    phase_e           state;
    phase_e           nextState;
    phase_e           succ;
    logic             advance;
    logic             timerDone;
    logic             inLeft;
    logic [3:0]       servedMask;
    logic [3:0]       clearMask;
    logic [3:0]       reqLatch;
    logic [3:0]       pair;

    phase_timer #(
        .CNT_W   (CNT_W),
        .RST_VAL (LD_ALLRED)
    ) uTimer (
        .clk     (clk),
        .resetn  (resetn),
        .load    (advance),
        .loadVal (loadFor(succ)),
        .tick    (tick),
        .done    (timerDone)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= EW_ALLRED;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        succ = nominalNext(state);
`ifdef SENSOR_SKIP_EN
        if ((state == NS_ALLRED) && ((reqLatch & EW_PAIR) == 4'b0000)) begin
            succ = EW_GREEN;
        end
        if ((state == EW_ALLRED) && ((reqLatch & NS_PAIR) == 4'b0000)) begin
            succ = NS_GREEN;
        end
`endif
        advance   = tick && timerDone;
        nextState = advance ? succ : state;
    end

    // Requests from the pair being served are dropped; leaving its left phase clears that pair, clear beating set.
    always_comb begin
        inLeft     = (state == NS_LEFT) || (state == EW_LEFT);
        servedMask = inLeft ? pairMask(state) : 4'b0000;
        clearMask  = (inLeft && advance) ? pairMask(state) : 4'b0000;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            reqLatch <= 4'b0000;
        end else begin
            reqLatch <= (reqLatch | (leftReq & ~servedMask)) & ~clearMask;
        end
    end

    always_comb begin
        pair      = pairMask(state);
        greenOut  = 4'b0000;
        yellowOut = 4'b0000;
        redOut    = 4'b1111;
        leftOut   = 4'b0000;
        case (state)
            NS_LEFT, EW_LEFT: begin
                leftOut = pair;
            end
            NS_GREEN, EW_GREEN: begin
                greenOut = pair;
                redOut   = ~pair;
            end
            NS_YELLOW, EW_YELLOW: begin
                yellowOut = pair;
                redOut    = ~pair;
            end
            default: begin
                redOut = 4'b1111;
            end
        endcase
        phase = {1'b0, state};
    end

endmodule
